// File: rtl/call_stack.sv
// ---------------------------------------------------------------------------
// call_stack
//   Hardware return-address stack. Entries are pushed from the decode-stage PC
//   and popped on return. All state updates on the falling edge of clk. The
//   storage array is never reset; only the pointer, the popped-data register and
//   the status flags are.
//
//   DEPTH must be a power of two and at least 2.
//
// Ports
//   clk        clock; state updates on its falling edge
//   rst        asynchronous active-low reset
//   push       write din onto the top of the stack
//   pop        remove the top-of-stack entry into data_out
//   din        value to push
//   data_out   registered value of the most recently popped entry
//   pop_valid  one-cycle pulse: data_out was refreshed by a successful pop
//   tos        current top-of-stack entry, 0 when empty
//   sp         current entry count, 0..DEPTH
//   empty      sp == 0
//   full       sp == DEPTH
//   clr_err    clears the sticky error flags
//   overflow   sticky: a push was rejected on a full stack
//   underflow  sticky: a pop was rejected on an empty stack
// ---------------------------------------------------------------------------
module call_stack #(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] data_out,
    output logic              pop_valid,
    output logic [DATA_W-1:0] tos,
    output logic [ADDR_W:0]   sp,
    output logic              empty,
    output logic              full,
    input  logic              clr_err,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0]   SP_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   SP_MAX  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] top_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic              wr_new;
    logic              wr_replace;
    logic              pop_ok;
    logic              pop_only;
    logic              push_rej;
    logic              pop_rej;
    logic              mem_we;

    // Pointer update clamped to 0..DEPTH; the decode never asks for a step
    // beyond the ends, but the clamp keeps sp from wrapping regardless.
    function automatic logic [ADDR_W:0] sp_step(input logic [ADDR_W:0] cur,
                                                input logic            inc,
                                                input logic            dec);
        logic [ADDR_W:0] nxt;
        nxt = cur;
        if (inc && !dec && cur != SP_MAX)
            nxt = cur + SP_ONE;
        else if (dec && !inc && cur != '0)
            nxt = cur - SP_ONE;
        return nxt;
    endfunction

    // Operation decode (combinational from sp and the request lines).
    // With sp == DEPTH the low ADDR_W bits wrap to 0, so top_idx still lands
    // on DEPTH-1.
    always_comb begin
        top_idx    = sp[ADDR_W-1:0] - IDX_ONE;
        empty      = (sp == '0);
        full       = (sp == SP_MAX);
        // Push together with pop on an empty stack degrades to a plain push.
        wr_new     = push && (!pop || empty) && !full;
        wr_replace = push && pop && !empty;
        pop_ok     = pop && !empty;
        pop_only   = pop && !push && !empty;
        push_rej   = push && !pop && full;
        pop_rej    = pop && !push && empty;
        mem_we     = wr_new || wr_replace;
        wr_idx     = wr_replace ? top_idx : sp[ADDR_W-1:0];
        tos        = empty ? '0 : mem[top_idx];
    end

    // Storage array: no reset, contents beyond sp are don't-care.
    always_ff @(negedge clk) begin
        if (mem_we)
            mem[wr_idx] <= din;
    end

    // Control and status registers.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            sp        <= '0;
            data_out  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_step(sp, wr_new, pop_only);
            pop_valid <= pop_ok;
            if (pop_ok)
                data_out <= mem[top_idx];
            // A fresh error wins over a clear on the same edge.
            if (push_rej)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (pop_rej)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

endmodule

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter DATA_W, default 19, width of each stored entry (return address).
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two, minimum 2.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), derived, not overridden by users.
REQ-004 Port clk  input  1  clock; all state SHALL update on the falling edge of clk.
REQ-005 Port rst  input  1  reset, asynchronous, active-low.
REQ-006 Port push  input  1  write din onto top of stack.
REQ-007 Port pop  input  1  remove top-of-stack entry.
REQ-008 Port din  input  DATA_W  data to push (PC of decode stage).
REQ-009 Port data_out  output  DATA_W  registered value of the most recently popped entry.
REQ-010 Port pop_valid  output  1  one-cycle pulse; data_out updated by a successful pop.
REQ-011 Port tos  output  DATA_W  current top-of-stack entry; 0 when empty.
REQ-012 Port sp  output  ADDR_W+1  current entry count, 0..DEPTH.
REQ-013 Port empty  output  1  high when sp==0.
REQ-014 Port full  output  1  high when sp==DEPTH.
REQ-015 Port clr_err  input  1  clears sticky error flags.
REQ-016 Port overflow  output  1  sticky; a push was rejected because the stack was full.
REQ-017 Port underflow  output  1  sticky; a pop was rejected because the stack was empty.

Function
REQ-018 Storage SHALL be a DEPTH x DATA_W register array; entry i is valid for i < sp; entry sp-1 is the top.
REQ-019 Push only, not full: mem[sp] <= din; sp <= sp+1; tos = din after the edge.
REQ-020 Push only, full: no write; sp unchanged; overflow <= 1.
REQ-021 Pop only, not empty: data_out <= mem[sp-1]; pop_valid <= 1; sp <= sp-1; tos = mem[sp-2], or 0 if the stack becomes empty.
REQ-022 Pop only, empty: sp, data_out unchanged; pop_valid <= 0; underflow <= 1.
REQ-023 Push and pop together, not empty (full included): replace top; data_out <= old mem[sp-1]; pop_valid <= 1; mem[sp-1] <= din; sp unchanged; no flag set.
REQ-024 Push and pop together, empty: treat as push only; underflow not set; pop_valid <= 0.
REQ-025 pop_valid SHALL be 0 on every edge without a successful pop; data_out SHALL hold its value otherwise.
REQ-026 tos, empty and full SHALL be combinational from sp and the array; no added latency beyond the update edge.
REQ-027 sp SHALL never exceed DEPTH or go below 0; no wrap-around.
REQ-028 clr_err high at an edge SHALL clear overflow and underflow; a new error on the same edge SHALL take priority and set its flag.
REQ-029 Operation with neither push nor pop SHALL leave all state unchanged, except pop_valid, which SHALL go to 0.

Reset
REQ-030 rst low SHALL immediately, independent of clk, force sp=0, data_out=0, pop_valid=0, overflow=0, underflow=0.
REQ-031 Array contents SHALL NOT be reset; after reset the stack is empty and tos reads 0.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight push or pop; the first edge after release SHALL behave as on an empty stack.

Verification (DATA_W=19, DEPTH=4)
REQ-033 Reset, then push 0x00010, 0x00020, 0x00030 on three edges -> sp=3, tos=0x00030, empty=0, full=0.
REQ-034 From REQ-033, pop twice -> data_out=0x00030 then 0x00020, pop_valid high on each edge, sp=1, tos=0x00010.
REQ-035 Fill to 4 entries, then push 0x7FFFF -> sp=4, full=1, overflow=1, tos unchanged; clr_err -> overflow=0.
REQ-036 Empty stack, pop -> underflow=1, pop_valid=0, data_out unchanged; push and pop together on empty -> sp=1, tos=din, underflow unchanged.
REQ-037 sp=2 with tos=0x00020, push and pop together with din=0x00055 -> data_out=0x00020, pop_valid=1, sp=2, tos=0x00055.
REQ-038 Assert rst between clock edges with sp=3 and overflow=1 -> sp=0, flags=0, data_out=0 before the next edge.
